// File: rtl/adder_selfcheck_if.sv
// Operand/result bus between the self-check engine and an N-bit adder under test.
// The engine takes the master side (drives operands, receives the sum);
// the adder under test takes the slave side.
interface adder_selfcheck_if #(
    parameter int N = 128
) ();
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic [N-1:0] s_duv;
    logic         cout_duv;

    modport master (
        output a, b, cin,
        input  s_duv, cout_duv
    );

    modport slave (
        input  a, b, cin,
        output s_duv, cout_duv
    );
endinterface

// File: rtl/adder_selfcheck.sv
// Self-checking stimulus/compare engine for N-bit adders.
// Issues NVEC operand vectors (LFSR random or carry-walk), computes the golden
// {cout,s} = a + b + cin, delays it by the adder latency LAT and counts mismatches.
module adder_selfcheck #(
    parameter int          N    = 128,
    parameter int          LAT  = 0,
    parameter int unsigned NVEC = 30000,
    parameter logic [31:0] SEED = 32'hACE1_2011
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     mode,
    adder_selfcheck_if.master        duv,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [15:0]              err_count,
    output logic [31:0]              vec_count,
    output logic [31:0]              first_err_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam int          KW         = $clog2(N + 2);
    localparam logic [31:0] LAST_IDX   = 32'(NVEC - 1);
    localparam logic [3:0]  DRAIN_INIT = 4'(LAT - 1);
    localparam logic [31:0] LFSR_MASK  = 32'h8020_0003;

    // Galois LFSR, x^32 + x^22 + x^2 + x + 1, right-shifting form.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 32'h0);
    endfunction

    // (N+1)-bit reference sum of a packed {cin, b, a} vector.
    function automatic logic [N:0] golden_sum(input logic [2*N:0] v);
        return {1'b0, v[N-1:0]} + {1'b0, v[2*N-1:N]} + {{N{1'b0}}, v[2*N]};
    endfunction

    // Error counter increment that sticks at all ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t             state_q, state_d;
    logic [3:0]         drain_q, drain_d;
    logic               mode_q;
    logic [31:0]        lfsr_q;
    logic [2*N:0]       stim_q;
    logic [KW-1:0]      k_q;
    logic [31:0]        vec_q;
    logic [15:0]        err_q;
    logic [31:0]        first_q;
    logic               busy_q;
    logic               done_q;

    logic [N:0]         gold_pipe_q [0:LAT];
    logic [31:0]        idx_pipe_q  [0:LAT];
    logic [LAT:0]       vld_pipe_q;

    logic               start_ok;
    logic               issue;
    logic [N-1:0]       walk_a;
    logic [2*N:0]       stim_base;
    logic [2*N:0]       stim_d;
    logic [N:0]         gold_d;
    logic               mismatch;

    assign start_ok  = start && ((state_q == IDLE) || (state_q == DONE));
    assign issue     = (state_q == RUN);
    assign walk_a    = ~({N{1'b1}} << k_q);
    // The random stream starts from an empty register on every run, so the
    // vector sequence depends only on SEED.
    assign stim_base = (vec_q == 32'd0) ? '0 : stim_q;
    assign stim_d    = mode_q ? {1'b1, {N{1'b0}}, walk_a}
                              : ((stim_base << 32) | {{(2*N-31){1'b0}}, lfsr_q});
    assign gold_d    = golden_sum(stim_d);
    assign mismatch  = vld_pipe_q[LAT] &&
                       ({duv.cout_duv, duv.s_duv} != gold_pipe_q[LAT]);

    assign duv.a         = stim_q[N-1:0];
    assign duv.b         = stim_q[2*N-1:N];
    assign duv.cin       = stim_q[2*N];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = done_q && (err_q == 16'd0);
    assign err_count     = err_q;
    assign vec_count     = vec_q;
    assign first_err_idx = first_q;

    // Next-state logic: RUN issues NVEC vectors, DRAIN waits out the adder latency.
    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (vec_q == LAST_IDX) begin
                    if (LAT == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_INIT;
                    end
                end
            end
            DRAIN: begin
                if (drain_q == 4'd0) state_d = DONE;
                else                 drain_d = drain_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control/stimulus registers; busy/done lag the state by one edge so they
    // line up with the registered operands and the last compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= 4'd0;
            mode_q  <= 1'b0;
            lfsr_q  <= SEED;
            stim_q  <= '0;
            k_q     <= '0;
            vec_q   <= 32'd0;
            err_q   <= 16'd0;
            first_q <= 32'hFFFF_FFFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            busy_q  <= (state_q == RUN) || (state_q == DRAIN);
            done_q  <= (state_q == DONE);
            if (start_ok) begin
                mode_q  <= mode;
                lfsr_q  <= SEED;
                k_q     <= '0;
                vec_q   <= 32'd0;
                err_q   <= 16'd0;
                first_q <= 32'hFFFF_FFFF;
            end else begin
                if (issue) begin
                    lfsr_q <= lfsr_step(lfsr_q);
                    stim_q <= stim_d;
                    vec_q  <= vec_q + 32'd1;
                    k_q    <= (k_q == KW'(N)) ? '0 : k_q + KW'(1);
                end
                if (mismatch) begin
                    err_q <= sat_inc16(err_q);
                    if (err_q == 16'd0) first_q <= idx_pipe_q[LAT];
                end
            end
        end
    end

    // Alignment delay line: stage 0 is loaded together with the operands,
    // stage LAT is compared against the adder output.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe_q <= '0;
        end else begin
            vld_pipe_q[0] <= issue;
            for (int j = 1; j <= LAT; j++) vld_pipe_q[j] <= vld_pipe_q[j-1];
        end
        gold_pipe_q[0] <= gold_d;
        idx_pipe_q[0]  <= vec_q;
        for (int j = 1; j <= LAT; j++) begin
            gold_pipe_q[j] <= gold_pipe_q[j-1];
            idx_pipe_q[j]  <= idx_pipe_q[j-1];
        end
    end
endmodule

// File: tb/tb_adder_selfcheck.sv
// Bench for adder_selfcheck: several engine instances run side by side against
// ideal, faulty and pipelined adder models, checked against hand-computed values.
module tb_adder_selfcheck;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst_x, rst_rnd, start_all, start_rnd;
    assign rst_rnd = rst | rst_x;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    adder_selfcheck_if #(.N(16))  if_cw  ();
    adder_selfcheck_if #(.N(16))  if_sa  ();
    adder_selfcheck_if #(.N(128)) if_rnd ();
    adder_selfcheck_if #(.N(32))  if_p3  ();
    adder_selfcheck_if #(.N(32))  if_p2  ();
    adder_selfcheck_if #(.N(16))  if_sat ();

    // Adder models
    assign {if_cw.cout_duv, if_cw.s_duv}   = {1'b0, if_cw.a} + {1'b0, if_cw.b} + 17'(if_cw.cin);
    assign {if_rnd.cout_duv, if_rnd.s_duv} = {1'b0, if_rnd.a} + {1'b0, if_rnd.b} + 129'(if_rnd.cin);
    logic [16:0] sa_sum;
    assign sa_sum          = {1'b0, if_sa.a} + {1'b0, if_sa.b} + 17'(if_sa.cin);
    assign if_sa.cout_duv  = sa_sum[16];
    assign if_sa.s_duv     = sa_sum[15:0] & 16'hFFDF;
    assign if_sat.s_duv    = 16'h0;
    assign if_sat.cout_duv = 1'b0;

    logic [32:0] p3_r1, p3_r2, p3_r3, p2_r1, p2_r2, p2_r3;
    always_ff @(posedge clk) begin
        if (rst) begin
            p3_r1 <= '0; p3_r2 <= '0; p3_r3 <= '0;
            p2_r1 <= '0; p2_r2 <= '0; p2_r3 <= '0;
        end else begin
            p3_r1 <= {1'b0, if_p3.a} + {1'b0, if_p3.b} + 33'(if_p3.cin);
            p3_r2 <= p3_r1; p3_r3 <= p3_r2;
            p2_r1 <= {1'b0, if_p2.a} + {1'b0, if_p2.b} + 33'(if_p2.cin);
            p2_r2 <= p2_r1; p2_r3 <= p2_r2;
        end
    end
    assign {if_p3.cout_duv, if_p3.s_duv} = p3_r3;
    assign {if_p2.cout_duv, if_p2.s_duv} = p2_r3;

    logic        cw_busy, cw_done, cw_pass, sa_busy, sa_done, sa_pass;
    logic        rnd_busy, rnd_done, rnd_pass, p3_busy, p3_done, p3_pass;
    logic        p2_busy, p2_done, p2_pass, sat_busy, sat_done, sat_pass;
    logic [15:0] cw_err, sa_err, rnd_err, p3_err, p2_err, sat_err;
    logic [31:0] cw_vec, sa_vec, rnd_vec, p3_vec, p2_vec, sat_vec;
    logic [31:0] cw_first, sa_first, rnd_first, p3_first, p2_first, sat_first;

    adder_selfcheck #(.N(16), .LAT(0), .NVEC(17)) u_cw (
        .clk(clk), .rst(rst), .start(start_all), .mode(1'b1), .duv(if_cw),
        .busy(cw_busy), .done(cw_done), .pass(cw_pass), .err_count(cw_err),
        .vec_count(cw_vec), .first_err_idx(cw_first));
    adder_selfcheck #(.N(16), .LAT(0), .NVEC(34)) u_sa (
        .clk(clk), .rst(rst), .start(start_all), .mode(1'b1), .duv(if_sa),
        .busy(sa_busy), .done(sa_done), .pass(sa_pass), .err_count(sa_err),
        .vec_count(sa_vec), .first_err_idx(sa_first));
    adder_selfcheck #(.N(128), .LAT(0), .NVEC(1000)) u_rnd (
        .clk(clk), .rst(rst_rnd), .start(start_rnd), .mode(1'b0), .duv(if_rnd),
        .busy(rnd_busy), .done(rnd_done), .pass(rnd_pass), .err_count(rnd_err),
        .vec_count(rnd_vec), .first_err_idx(rnd_first));
    adder_selfcheck #(.N(32), .LAT(3), .NVEC(200)) u_p3 (
        .clk(clk), .rst(rst), .start(start_all), .mode(1'b0), .duv(if_p3),
        .busy(p3_busy), .done(p3_done), .pass(p3_pass), .err_count(p3_err),
        .vec_count(p3_vec), .first_err_idx(p3_first));
    adder_selfcheck #(.N(32), .LAT(2), .NVEC(200)) u_p2 (
        .clk(clk), .rst(rst), .start(start_all), .mode(1'b0), .duv(if_p2),
        .busy(p2_busy), .done(p2_done), .pass(p2_pass), .err_count(p2_err),
        .vec_count(p2_vec), .first_err_idx(p2_first));
    adder_selfcheck #(.N(16), .LAT(0), .NVEC(66000)) u_sat (
        .clk(clk), .rst(rst), .start(start_all), .mode(1'b0), .duv(if_sat),
        .busy(sat_busy), .done(sat_done), .pass(sat_pass), .err_count(sat_err),
        .vec_count(sat_vec), .first_err_idx(sat_first));

    logic [63:0] rnd_seq [0:7];
    int cw_de, sa_de, rnd_de, p3_de, p2_de, sat_de;

    initial begin
        rst = 1'b1; rst_x = 1'b0; start_all = 1'b0; start_rnd = 1'b0;
        cw_de = 0; sa_de = 0; rnd_de = 0; p3_de = 0; p2_de = 0; sat_de = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("rst_a",     64'(if_cw.a),   64'h0);
        chk_eq("rst_b",     64'(if_cw.b),   64'h0);
        chk_eq("rst_cin",   64'(if_cw.cin), 64'h0);
        chk_eq("rst_busy",  64'(cw_busy),   64'h0);
        chk_eq("rst_done",  64'(cw_done),   64'h0);
        chk_eq("rst_pass",  64'(cw_pass),   64'h0);
        chk_eq("rst_err",   64'(cw_err),    64'h0);
        chk_eq("rst_vec",   64'(cw_vec),    64'h0);
        chk_eq("rst_first", 64'(cw_first),  64'hFFFF_FFFF);

        // Edge E0: every engine samples start here.
        start_all = 1'b1; start_rnd = 1'b1;
        @(negedge clk);
        start_all = 1'b0; start_rnd = 1'b0;
        chk_eq("cw_busy_e0", 64'(cw_busy), 64'h0);

        for (int e = 1; e <= 66100 && sat_de == 0; e++) begin
            @(negedge clk);
            if (e == 1) begin
                chk_eq("cw_busy_e1", 64'(cw_busy), 64'h1);
                chk_eq("cw_v0_a",    64'(if_cw.a), 64'h0);
                chk_eq("cw_v0_cin",  64'(if_cw.cin), 64'h1);
                chk_eq("rnd_v0_a",   if_rnd.a[63:0], 64'h0000_0000_ACE1_2011);
                chk_eq("rnd_v0_b",   if_rnd.b[63:0], 64'h0);
                chk_eq("rnd_vec_e1", 64'(rnd_vec), 64'd1);
            end
            if (e == 2) chk_eq("rnd_v1_a", if_rnd.a[63:0], 64'hACE1_2011_D650_900B);
            if (e >= 1 && e <= 8) rnd_seq[e-1] = if_rnd.a[63:0];
            if (e == 6) chk_eq("cw_v5_a", 64'(if_cw.a), 64'h001F);
            // A start pulse while running must be ignored by every engine.
            if (e == 10) start_all = 1'b1;
            if (e == 11) start_all = 1'b0;
            if (e == 17) begin
                chk_eq("cw_v16_a",   64'(if_cw.a),   64'hFFFF);
                chk_eq("cw_v16_b",   64'(if_cw.b),   64'h0);
                chk_eq("cw_v16_cin", 64'(if_cw.cin), 64'h1);
                chk_eq("cw_done_e17", 64'(cw_done),  64'h0);
            end
            if (e == 51) begin
                chk_eq("rnd_vec_e51", 64'(rnd_vec), 64'd51);
                rst_x = 1'b1;
            end
            if (e == 52) begin
                rst_x = 1'b0;
                chk_eq("rnd_mid_a",     if_rnd.a[63:0], 64'h0);
                chk_eq("rnd_mid_cin",   64'(if_rnd.cin), 64'h0);
                chk_eq("rnd_mid_busy",  64'(rnd_busy),  64'h0);
                chk_eq("rnd_mid_vec",   64'(rnd_vec),   64'h0);
                chk_eq("rnd_mid_err",   64'(rnd_err),   64'h0);
                chk_eq("rnd_mid_first", 64'(rnd_first), 64'hFFFF_FFFF);
                chk_eq("rnd_mid_done",  64'(rnd_done),  64'h0);
                start_rnd = 1'b1;
            end
            if (e == 53) begin
                start_rnd = 1'b0;
                chk_eq("rnd_restart_vec", 64'(rnd_vec), 64'h0);
            end
            if (e >= 54 && e <= 61) chk_eq("rnd_replay_a", if_rnd.a[63:0], rnd_seq[e-54]);

            if (cw_done && cw_de == 0) begin
                cw_de = e;
                chk_eq("cw_pass",  64'(cw_pass),  64'h1);
                chk_eq("cw_first", 64'(cw_first), 64'hFFFF_FFFF);
                chk_eq("cw_busy_done", 64'(cw_busy), 64'h0);
            end
            if (sa_done && sa_de == 0) begin
                sa_de = e;
                chk_eq("sa_err",   64'(sa_err),   64'd2);
                chk_eq("sa_first", 64'(sa_first), 64'd5);
                chk_eq("sa_pass",  64'(sa_pass),  64'h0);
            end
            if (p3_done && p3_de == 0) begin
                p3_de = e;
                chk_eq("p3_pass", 64'(p3_pass), 64'h1);
                chk_eq("p3_err",  64'(p3_err),  64'h0);
            end
            if (p2_done && p2_de == 0) begin
                p2_de = e;
                chk_eq("p2_err_nonzero", 64'(p2_err != 16'd0), 64'h1);
                chk_eq("p2_first", 64'(p2_first), 64'h0);
                chk_eq("p2_pass",  64'(p2_pass),  64'h0);
            end
            if (rnd_done && rnd_de == 0) begin
                rnd_de = e;
                chk_eq("rnd_pass", 64'(rnd_pass), 64'h1);
                chk_eq("rnd_vec",  64'(rnd_vec),  64'd1000);
                chk_eq("rnd_err",  64'(rnd_err),  64'h0);
            end
            if (sat_done && sat_de == 0) begin
                sat_de = e;
                chk_eq("sat_err",  64'(sat_err),  64'hFFFF);
                chk_eq("sat_pass", 64'(sat_pass), 64'h0);
                chk_eq("sat_vec",  64'(sat_vec),  64'd66000);
            end
        end

        chk_eq("cw_done_edge",  64'(cw_de),  64'd18);
        chk_eq("sa_done_edge",  64'(sa_de),  64'd35);
        chk_eq("p3_done_edge",  64'(p3_de),  64'd204);
        chk_eq("p2_done_edge",  64'(p2_de),  64'd203);
        chk_eq("rnd_done_edge", 64'(rnd_de), 64'd1054);
        chk_eq("sat_done_edge", 64'(sat_de), 64'd66001);
        @(negedge clk);
        chk_eq("sat_err_hold", 64'(sat_err), 64'hFFFF);
        chk_eq("cw_done_hold", 64'(cw_done), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
